// File: rtl/dmem_pkg.sv
// dmem_pkg: access-size encodings, FSM states, MMIO offsets and the load
// lane-extraction helper shared by the data-memory controller.
package dmem_pkg;

    // Access size encodings carried on the length port.
    localparam logic [1:0] LEN_B = 2'd0;
    localparam logic [1:0] LEN_H = 2'd1;
    localparam logic [1:0] LEN_W = 2'd2;
    localparam logic [1:0] LEN_X = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_e;

    // Word offsets inside the MMIO window.
    localparam logic [31:0] OFF_SW  = 32'd0;
    localparam logic [31:0] OFF_LED = 32'd4;

    // Pick the addressed byte/half out of a 32-bit word and extend it.
    function automatic logic [31:0] lane_extract(input logic [31:0] word,
                                                 input logic [1:0]  lane,
                                                 input logic [1:0]  len,
                                                 input logic        sign);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[{lane, 3'b000} +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        case (len)
            LEN_B:   return sign ? {{24{b[7]}}, b} : {24'h0, b};
            LEN_H:   return sign ? {{16{h[15]}}, h} : {16'h0, h};
            LEN_W:   return word;
            default: return 32'h0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_bram.sv
// dmem_bram: single-port word RAM with per-byte write enables and a
// registered (synchronous) read port, written to map onto block RAM.
module dmem_bram #(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned AW          = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem_q [0:DEPTH_WORDS-1];
    logic [31:0] rdata_q;

    // Byte-lane writes and read-first registered read.
    // NOTE: the array has no reset branch; a reset would turn it into flops instead of block RAM.
    always_ff @(posedge clk) begin
        if (en_i) begin
            for (int i = 0; i < 4; i++) begin
                if (we_i[i]) mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
            end
            rdata_q <= mem_q[addr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// data_mem_ctrl: load/store controller with byte/half/word accesses, a
// switch/LED MMIO window and a req/ready/ack handshake (IDLE->ACCESS->RESP).
// Build option: define DMEM_SW_SYNC_EN to pass sw_in through a two-flop
// synchronizer before it is read.
module data_mem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned DEPTH_WORDS = 4096,
    parameter int unsigned SW_W        = 16,
    parameter int unsigned LED_W       = 16,
    parameter logic [31:0] MMIO_BASE   = 32'h8000_0000
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req,
    input  logic             we,
    input  logic [1:0]       length,
    input  logic             sign,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic             ready,
    output logic             ack,
    output logic [31:0]      rdata,
    output logic             err,
    input  logic [SW_W-1:0]  sw_in,
    output logic [LED_W-1:0] led
);

    localparam int unsigned AW = $clog2(DEPTH_WORDS);

    state_e             state_q, state_d;
    logic               we_q, sign_q;
    logic [1:0]         len_q;
    logic [31:0]        addr_q, wdata_q;
    logic [31:0]        mmio_q;
    logic [LED_W-1:0]   led_q, led_d;
    logic [SW_W-1:0]    sw_src;
    logic [31:0]        sw_ext, led_ext, ram_rdata, rd_src, mmio_off, wrep;
    logic [3:0]         be, ram_we;
    logic               misalign, is_mmio, fault, led_we;

`ifdef DMEM_SW_SYNC_EN
    logic [SW_W-1:0] sw_meta_q, sw_sync_q;

    // Two-flop synchronizer for the asynchronous switch inputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= sw_in;
            sw_sync_q <= sw_meta_q;
        end
    end

    assign sw_src = sw_sync_q;
`else
    assign sw_src = sw_in;
`endif

    // State register.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Classify the latched access and build lane enables / replicated store data.
    always_comb begin
        // NOTE: every output of this block gets a default first so no path infers a latch.
        misalign = (len_q == LEN_X) ||
                   (len_q == LEN_H && addr_q[0]) ||
                   (len_q == LEN_W && addr_q[1:0] != 2'b00);
        is_mmio  = addr_q[31];
        mmio_off = {addr_q[31:2], 2'b00} - MMIO_BASE;
        be       = 4'b0000;
        wrep     = wdata_q;
        case (len_q)
            LEN_B: begin
                be   = 4'b0001 << addr_q[1:0];
                wrep = {4{wdata_q[7:0]}};
            end
            LEN_H: begin
                be   = addr_q[1] ? 4'b1100 : 4'b0011;
                wrep = {2{wdata_q[15:0]}};
            end
            LEN_W:   be = 4'b1111;
            default: be = 4'b0000;
        endcase
        if (misalign)              fault = 1'b1;
        else if (!is_mmio)         fault = ({2'b00, addr_q[31:2]} >= DEPTH_WORDS);
        else if (mmio_off == OFF_SW)  fault = we_q;
        else if (mmio_off == OFF_LED) fault = 1'b0;
        else                       fault = 1'b1;
    end

    // Side effects only happen in ACCESS; an async reset forces IDLE, which
    // also suppresses a write on an edge that coincides with reset.
    assign ram_we = (state_q == ACCESS && we_q && !fault && !is_mmio) ? be : 4'b0000;
    assign led_we = (state_q == ACCESS && we_q && !fault && is_mmio && mmio_off == OFF_LED);

    // Zero-extend the MMIO sources and merge byte-enabled LED writes.
    always_comb begin
        sw_ext  = '0;
        sw_ext[SW_W-1:0] = sw_src;
        led_ext = '0;
        led_ext[LED_W-1:0] = led_q;
        led_d   = led_q;
        for (int i = 0; i < LED_W; i++) begin
            if (be[i / 8]) led_d[i] = wrep[i];
        end
    end

    // Request latch, MMIO read capture and LED register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            len_q   <= LEN_B;
            sign_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            mmio_q  <= '0;
            led_q   <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                we_q    <= we;
                len_q   <= length;
                sign_q  <= sign;
                addr_q  <= addr;
                wdata_q <= wdata;
            end
            if (state_q == ACCESS) mmio_q <= (mmio_off == OFF_LED) ? led_ext : sw_ext;
            if (led_we) led_q <= led_d;
        end
    end

    dmem_bram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_bram (
        .clk     (clk),
        .en_i    (state_q == ACCESS),
        .we_i    (ram_we),
        .addr_i  (addr_q[AW+1:2]),
        .wdata_i (wrep),
        .rdata_o (ram_rdata)
    );

    assign rd_src = is_mmio ? mmio_q : ram_rdata;

    // Next-state logic and handshake outputs.
    always_comb begin
        state_d = state_q;
        ready   = 1'b0;
        ack     = 1'b0;
        err     = 1'b0;
        rdata   = '0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (req) state_d = ACCESS;
            end
            ACCESS: state_d = RESP;
            RESP: begin
                ack     = 1'b1;
                err     = fault;
                if (!fault && !we_q) rdata = lane_extract(rd_src, addr_q[1:0], len_q, sign_q);
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign led = led_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb_data_mem_ctrl: directed and randomized accesses against a byte-level
// reference model of the data memory, switch and LED registers.
module tb_data_mem_ctrl;

    localparam int unsigned DEPTH    = 4096;
    localparam int unsigned SW_W     = 16;
    localparam int unsigned LED_W    = 16;
    localparam logic [31:0] MMIO     = 32'h8000_0000;
    localparam logic [31:0] LED_MASK = 32'h0000_FFFF;

    logic             clk = 1'b0;
    logic             rst;
    logic             req, we, sign;
    logic [1:0]       length;
    logic [31:0]      addr, wdata;
    logic             ready, ack, err;
    logic [31:0]      rdata;
    logic [SW_W-1:0]  sw_in;
    logic [LED_W-1:0] led;

    always #5 clk = ~clk;

    data_mem_ctrl #(
        .DEPTH_WORDS (DEPTH),
        .SW_W        (SW_W),
        .LED_W       (LED_W),
        .MMIO_BASE   (MMIO)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .req    (req),
        .we     (we),
        .length (length),
        .sign   (sign),
        .addr   (addr),
        .wdata  (wdata),
        .ready  (ready),
        .ack    (ack),
        .rdata  (rdata),
        .err    (err),
        .sw_in  (sw_in),
        .led    (led)
    );

    typedef struct {
        int          due;
        logic [31:0] rd;
        logic        err;
        logic [31:0] led;
    } exp_t;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc      = 0;
    bit          chk_en   = 1'b0;
    exp_t        exp_q[$];
    int          ack_log[$];
    logic [31:0] last_rd;
    logic        last_err;

    // Reference state: memory as individual bytes, LED as a plain word.
    bit [7:0]    mem_b [bit [31:0]];
    logic [31:0] led_m = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Apply one access to the reference state and return the expected response.
    function automatic void model_access(input logic w, input logic [1:0] len, input logic sg,
                                         input logic [31:0] a, input logic [31:0] wd,
                                         output logic [31:0] rd, output logic e);
        int unsigned n;
        logic [31:0] val, mask, off;
        n   = (len == 2'd0) ? 1 : (len == 2'd1) ? 2 : (len == 2'd2) ? 4 : 0;
        rd  = '0;
        e   = 1'b0;
        val = '0;
        if (n == 0) e = 1'b1;
        else if ((a % n) != 0) e = 1'b1;
        else if (a < MMIO) begin
            if (a >= 4 * DEPTH) e = 1'b1;
            else begin
                for (int i = 0; i < n; i++) begin
                    if (w) mem_b[a + i] = wd[8*i +: 8];
                    else   val = val | (32'(mem_b[a + i]) << (8 * i));
                end
            end
        end else begin
            off = a - MMIO;
            if (off < 4) begin
                if (w) e = 1'b1;
                else   val = 32'(sw_in) >> (8 * off);
            end else if (off < 8) begin
                if (w) begin
                    for (int i = 0; i < n; i++) led_m[8*(off - 4 + i) +: 8] = wd[8*i +: 8];
                    led_m = led_m & LED_MASK;
                end else begin
                    val = led_m >> (8 * (off - 4));
                end
            end else e = 1'b1;
        end
        if (!e && !w) begin
            mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
            val  = val & mask;
            if (sg && n < 4 && val[8*n-1]) val = val | ~mask;
            rd = val;
        end
    endfunction

    task automatic wait_ready();
        for (int k = 0; k < 20 && ready !== 1'b1; k++) begin
            @(negedge clk);
            #1;
        end
        check("ready_before_req", 32'(ready), 32'd1);
    endtask

    // Present one request for a single accepting edge; queue its expected response.
    task automatic issue(input logic w, input logic [1:0] len, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd);
        exp_t        e;
        logic [31:0] prd;
        logic        perr;
        wait_ready();
        if (ready === 1'b1) begin
            req = 1'b1; we = w; length = len; sign = sg; addr = a; wdata = wd;
            model_access(w, len, sg, a, wd, prd, perr);
            e.rd = prd; e.err = perr; e.led = led_m; e.due = cyc + 2;
            exp_q.push_back(e);
            @(negedge clk);
            #1;
            req = 1'b0;
        end
    endtask

    task automatic wait_done();
        for (int k = 0; k < 10 && exp_q.size() != 0; k++) begin
            @(negedge clk);
            #1;
        end
        check("pending_responses", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic xfer(input logic w, input logic [1:0] len, input logic sg,
                        input logic [31:0] a, input logic [31:0] wd);
        issue(w, len, sg, a, wd);
        wait_done();
    endtask

    // Compare process: every cycle, ack must be high exactly when a response is due.
    always @(negedge clk) begin : cmp
        exp_t cur;
        if (chk_en && rst === 1'b1) begin
            if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
                cur = exp_q.pop_front();
                check("ack", 32'(ack), 32'd1);
                check("rdata", rdata, cur.rd);
                check("err", 32'(err), 32'(cur.err));
                check("led", 32'(led), cur.led);
                last_rd  <= rdata;
                last_err <= err;
            end else begin
                check("unexpected_ack", 32'(ack), 32'd0);
            end
            if (ack === 1'b1) ack_log.push_back(cyc);
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int          c;
        logic [31:0] a, prd;
        logic [1:0]  len;
        logic        perr;
        exp_t        e;

        rst = 1'b0; req = 1'b0; we = 1'b0; length = 2'd0; sign = 1'b0;
        addr = '0; wdata = '0; sw_in = '0;
        repeat (3) @(negedge clk);
        #1;
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_ack", 32'(ack), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        check("rst_rdata", rdata, 32'd0);
        check("rst_led", 32'(led), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        chk_en = 1'b1;

        // Byte loads of a stored word, sign- and zero-extended.
        xfer(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF);
        xfer(1'b0, 2'd0, 1'b1, 32'h13, 32'h0);
        check("lb_signed", last_rd, 32'hFFFF_FFDE);
        check("lb_signed_err", 32'(last_err), 32'd0);
        xfer(1'b0, 2'd0, 1'b0, 32'h13, 32'h0);
        check("lb_unsigned", last_rd, 32'h0000_00DE);

        // Half store keeps the lower lanes.
        xfer(1'b1, 2'd1, 1'b0, 32'h12, 32'h0000_1234);
        xfer(1'b0, 2'd2, 1'b0, 32'h10, 32'h0);
        check("sh_merge", last_rd, 32'h1234_BEEF);

        // Misaligned accesses fault without side effects.
        xfer(1'b0, 2'd1, 1'b0, 32'h11, 32'h0);
        check("lh_misaligned_err", 32'(last_err), 32'd1);
        check("lh_misaligned_rdata", last_rd, 32'd0);
        xfer(1'b1, 2'd2, 1'b0, 32'h20, 32'h1111_2222);
        xfer(1'b1, 2'd2, 1'b0, 32'h22, 32'hFFFF_FFFF);
        check("sw_misaligned_err", 32'(last_err), 32'd1);
        xfer(1'b0, 2'd2, 1'b0, 32'h20, 32'h0);
        check("sw_misaligned_nowrite", last_rd, 32'h1111_2222);

        // Switches and LEDs.
        sw_in = 16'h8001;
        repeat (3) @(negedge clk);
        #1;
        xfer(1'b0, 2'd1, 1'b1, MMIO, 32'h0);
        check("sw_load_half", last_rd, 32'hFFFF_8001);
        xfer(1'b1, 2'd0, 1'b0, MMIO + 32'd5, 32'h0000_00A5);
        check("led_byte_store", 32'(led), 32'h0000_A500);
        xfer(1'b1, 2'd2, 1'b0, MMIO, 32'h0000_FFFF);
        check("sw_store_err", 32'(last_err), 32'd1);
        check("sw_store_led", 32'(led), 32'h0000_A500);

        // Out-of-range word index.
        xfer(1'b0, 2'd2, 1'b0, 4 * DEPTH, 32'h0);
        check("oor_err", 32'(last_err), 32'd1);
        check("oor_rdata", last_rd, 32'd0);

        // req held through RESP: second ack three cycles after the first.
        ack_log.delete();
        wait_ready();
        req = 1'b1; we = 1'b0; length = 2'd2; sign = 1'b0; addr = 32'h10; wdata = '0;
        c = cyc;
        for (int k = 0; k < 2; k++) begin
            model_access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, prd, perr);
            e.rd = prd; e.err = perr; e.led = led_m; e.due = c + 2 + 3 * k;
            exp_q.push_back(e);
        end
        while (cyc < c + 4) begin
            @(negedge clk);
            #1;
        end
        req = 1'b0;
        wait_done();
        check("held_ack_count", 32'(ack_log.size()), 32'd2);
        if (ack_log.size() == 2) check("held_ack_spacing", 32'(ack_log[1] - ack_log[0]), 32'd3);

        // Fill two memory regions so random loads only read defined data.
        for (int i = 0; i < 64; i++) xfer(1'b1, 2'd2, 1'b0, 32'(4 * i), $urandom);
        for (int i = 0; i < 64; i++) xfer(1'b1, 2'd2, 1'b0, 32'h3F00 + 32'(4 * i), $urandom);

        // Randomized mix of sizes, alignments, regions and directions.
        for (int t = 0; t < 300; t++) begin
            if ($urandom_range(0, 19) == 0) begin
                sw_in = SW_W'($urandom);
                repeat (3) @(negedge clk);
                #1;
            end
            len = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: a = 32'($urandom_range(0, 255));
                5, 6:          a = 32'h3F00 + 32'($urandom_range(0, 255));
                7:             a = ($urandom_range(0, 1) != 0) ? 32'h4000 + 32'($urandom_range(0, 255))
                                                               : 32'h7FFF_FF00 + 32'($urandom_range(0, 255));
                default:       a = MMIO + 32'($urandom_range(0, 15));
            endcase
            if ($urandom_range(0, 1) != 0 && len != 2'd3) begin
                if (len == 2'd1) a[0] = 1'b0;
                if (len == 2'd2) a[1:0] = 2'b00;
            end
            xfer(1'($urandom_range(0, 1)), len, 1'($urandom_range(0, 1)), a, $urandom);
        end

        // Reset asserted during ACCESS of a store aborts it.
        xfer(1'b1, 2'd2, 1'b0, 32'h0, 32'hCAFE_F00D);
        xfer(1'b1, 2'd0, 1'b0, MMIO + 32'd4, 32'h0000_0077);
        wait_ready();
        req = 1'b1; we = 1'b1; length = 2'd2; sign = 1'b0; addr = 32'h0; wdata = 32'h1;
        @(negedge clk);
        #1;
        req = 1'b0;
        rst = 1'b0;
        #1;
        check("abort_ready", 32'(ready), 32'd1);
        check("abort_ack", 32'(ack), 32'd0);
        check("abort_led", 32'(led), 32'd0);
        led_m = '0;
        @(negedge clk);
        #1;
        check("abort_ack_next", 32'(ack), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        #1;
        xfer(1'b0, 2'd2, 1'b0, 32'h0, 32'h0);
        check("abort_word0", last_rd, 32'hCAFE_F00D);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
